start_fifo_srl_ctrl: RTL and testbench
======================================

# start_fifo_srl_ctrl

Control sequencer for the SRL shift-register storage used by the inter-PE start/data FIFOs in the Linear_Layer dataflow. It drives the shift register's `we`/`addr` ports, keeps the occupancy count, and adds a registered first-word-fall-through output stage. It presents the standard `if_*` FIFO handshake to producer and consumer processes. One instance pairs with one shift-register instance of matching DATA_WIDTH, ADDR_WIDTH and DEPTH.

## Interface
- DATA_WIDTH, 1, word width; equals the paired shift register's DATA_WIDTH.
- ADDR_WIDTH, 1, shift-register address width; 2^ADDR_WIDTH >= DEPTH.
- DEPTH, 2, shift-register entries. Total FIFO capacity is DEPTH+1 (shift register plus output register).
- AFULL_THRESH, DEPTH, occupancy at or above which `if_almost_full` asserts; range 1..DEPTH+1.

Ports:
- clk  in  1  sole clock; all logic is rising-edge.
- reset_n  in  1  synchronous, active-low reset.
- flush  in  1  synchronous clear of all contents.
- if_write_ce  in  1  write clock-enable.
- if_write  in  1  write request.
- if_din  in  DATA_WIDTH  write data.
- if_full_n  out  1  1 = a write is accepted this cycle.
- if_almost_full  out  1  occupancy >= AFULL_THRESH.
- if_read_ce  in  1  read clock-enable.
- if_read  in  1  read request / consume head.
- if_dout  out  DATA_WIDTH  head word (registered).
- if_empty_n  out  1  1 = `if_dout` is valid.
- num_data_valid  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH+1.
- fifo_cap  out  ADDR_WIDTH+1  constant DEPTH+1.
- sr_we  out  1  shift-register shift enable.
- sr_addr  out  ADDR_WIDTH  shift-register read address.
- sr_din  out  DATA_WIDTH  shift-register input data; wired to `if_din`.
- sr_dout  in  DATA_WIDTH  shift-register output at `sr_addr`.

## Operation
- State registers:
  - `cnt` (0..DEPTH): words held in the shift register.
  - `dout_vld`: output-register valid.
  - `dout_r`: output-register data.
  - `full_n_r`: registered full flag.
- push = if_write & if_write_ce & full_n_r. `sr_we` = push; the new word enters slot 0 and older words shift up.
- The oldest shift-register word sits in slot cnt-1. `sr_addr` = cnt-1 when cnt > 0, else 0.
- pop = if_read & if_read_ce & dout_vld.
- load = (cnt > 0) & (!dout_vld | pop). On load, `dout_r` <= `sr_dout`, sampled before that edge's shift. This is correct when push and load occur together.
- cnt_next = cnt + push - load.
- dout_vld_next = load | (dout_vld & !pop).
- full_n_r_next = (cnt_next < DEPTH).
- Combinational outputs from registered state:
  - num_data_valid = cnt + dout_vld.
  - if_almost_full = (num_data_valid >= AFULL_THRESH).
  - if_empty_n = dout_vld.
  - if_dout = dout_r.
- flush has priority over push and pop. On a flush edge: cnt=0, dout_vld=0, full_n_r=1. A push presented in a flush cycle is dropped and `sr_we` is forced 0. `dout_r` keeps its value.
- if_write while full, or if_read while empty, is ignored. No state changes and no error is flagged.
- Requests with the matching _ce low are ignored.
- Ordering is strict FIFO. No word is lost or duplicated under any push/pop/load combination.

## Timing
- Reset (reset_n=0 at an edge): cnt=0, dout_vld=0, dout_r=0, full_n_r=1. Resulting outputs:
  - if_empty_n=0, if_full_n=1, num_data_valid=0, if_almost_full=0 (AFULL_THRESH >= 1).
  - sr_we=0 throughout reset.
- Reset asserted mid-operation discards all contents at that edge. Flush does the same.
- Write-to-read latency: a word pushed at edge k is in the shift register after k. It loads into the output register at edge k+1, so if_empty_n=1 from k+1 when the FIFO was empty.
- Steady-state throughput is one push and one pop per cycle, with no bubbles while cnt > 0.
- if_full_n falls in the cycle after the push that makes cnt=DEPTH. Because full_n_r is registered, an accepted push never overflows.
- Full with simultaneous pop: the load frees a slot, and if_full_n rises in the next cycle.
- Empty with simultaneous write and read: the read is ignored and the write is accepted.

## Test plan
- Reset, then idle: if_empty_n=0, if_full_n=1, num_data_valid=0, fifo_cap=DEPTH+1. sr_we stays 0.
- DEPTH=4, write 0xA at cycle 0: if_empty_n=1 and if_dout=0xA from cycle 2. Read it: num_data_valid returns to 0 and if_empty_n=0 the next cycle.
- DEPTH=4, write 1..6 back-to-back with no reads:
  - Words 1..5 are accepted and if_full_n=0 after the 5th.
  - The write of 6 is ignored and num_data_valid=5.
  - Draining yields 1,2,3,4,5 in order.
- DEPTH=4, continuous simultaneous write/read of an incrementing stream for 100 cycles after a prefill of 2: the output sequence is gap-free and in order, and num_data_valid holds at 2 or 3.
- AFULL_THRESH=3, DEPTH=4: if_almost_full rises exactly when num_data_valid reaches 3 and falls when it drops to 2.
- Fill with 3 words, then assert flush together with a write of 0xF: next cycle num_data_valid=0 and if_empty_n=0. A subsequent write of 0x7 is read back as 0x7.
- A further reset_n pulse mid-stream gives the same result as flush; all subsequent reads return only post-reset data.

Source files
------------

// File: rtl/start_fifo_srl_ctrl.sv
// start_fifo_srl_ctrl: sequences an external SRL shift register as a FIFO with a registered first-word-fall-through output stage
module start_fifo_srl_ctrl #(
  parameter int DATA_WIDTH   = 1,
  parameter int ADDR_WIDTH   = 1,
  parameter int DEPTH        = 2,
  parameter int AFULL_THRESH = DEPTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  if_write_ce,
  input  logic                  if_write,
  input  logic [DATA_WIDTH-1:0] if_din,
  output logic                  if_full_n,
  output logic                  if_almost_full,
  input  logic                  if_read_ce,
  input  logic                  if_read,
  output logic [DATA_WIDTH-1:0] if_dout,
  output logic                  if_empty_n,
  output logic [ADDR_WIDTH:0]   num_data_valid,
  output logic [ADDR_WIDTH:0]   fifo_cap,
  output logic                  sr_we,
  output logic [ADDR_WIDTH-1:0] sr_addr,
  output logic [DATA_WIDTH-1:0] sr_din,
  input  logic [DATA_WIDTH-1:0] sr_dout
);
  typedef logic [ADDR_WIDTH:0] cnt_t;
  cnt_t                  cnt_q, cnt_d;
  logic                  vld_q, vld_d, full_n_q, full_n_d;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  push, pop, load;
  assign push = if_write & if_write_ce & full_n_q;
  assign pop  = if_read & if_read_ce & vld_q;
  // sr_dout is sampled before this edge's shift, so load is safe alongside push
  assign load = (cnt_q != '0) & (~vld_q | pop);
  assign cnt_d    = cnt_q + cnt_t'(push) - cnt_t'(load);
  assign vld_d    = load | (vld_q & ~pop);
  assign full_n_d = cnt_d < cnt_t'(DEPTH);
  assign sr_we          = push & reset_n & ~flush;
  assign sr_addr        = (cnt_q != '0) ? ADDR_WIDTH'(cnt_q - cnt_t'(1)) : '0;
  assign sr_din         = if_din;
  assign if_full_n      = full_n_q;
  assign if_empty_n     = vld_q;
  assign if_dout        = dout_q;
  assign num_data_valid = cnt_q + cnt_t'(vld_q);
  assign if_almost_full = num_data_valid >= cnt_t'(AFULL_THRESH);
  assign fifo_cap       = cnt_t'(DEPTH + 1);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      vld_q    <= 1'b0;
      dout_q   <= '0;
      full_n_q <= 1'b1;
    end else if (flush) begin
      cnt_q    <= '0;
      vld_q    <= 1'b0;
      full_n_q <= 1'b1;
    end else begin
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      full_n_q <= full_n_d;
      if (load) dout_q <= sr_dout;
    end
  end
endmodule

// File: tb/tb_start_fifo_srl_ctrl.sv
// tb_start_fifo_srl_ctrl: randomized scoreboard bench with a queue-based FIFO reference model and a behavioural SRL
module tb_start_fifo_srl_ctrl;
  localparam int DW = 8, AW = 2, DEPTH = 4, AF = 3;
  logic clk = 0, reset_n = 0, flush = 0;
  logic if_write_ce = 0, if_write = 0, if_read_ce = 0, if_read = 0;
  logic [DW-1:0] if_din = '0, if_dout, sr_din, sr_dout;
  logic if_full_n, if_almost_full, if_empty_n, sr_we;
  logic [AW:0] num_data_valid, fifo_cap;
  logic [AW-1:0] sr_addr;
  logic [DW-1:0] srl [DEPTH];
  int checks = 0, errors = 0, edge_no = 0;
  bit started = 0, m_po, m_pu;
  int mq[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] nv = 1;

  always #5 clk = ~clk;

  start_fifo_srl_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH), .AFULL_THRESH(AF)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .if_write_ce(if_write_ce), .if_write(if_write), .if_din(if_din),
    .if_full_n(if_full_n), .if_almost_full(if_almost_full),
    .if_read_ce(if_read_ce), .if_read(if_read), .if_dout(if_dout), .if_empty_n(if_empty_n),
    .num_data_valid(num_data_valid), .fifo_cap(fifo_cap),
    .sr_we(sr_we), .sr_addr(sr_addr), .sr_din(sr_din), .sr_dout(sr_dout));

  // Behavioural shift register: new word in slot 0, older words move up
  always @(posedge clk) if (sr_we) begin
    for (int i = DEPTH - 1; i > 0; i--) srl[i] <= srl[i-1];
    srl[0] <= sr_din;
  end
  assign sr_dout = srl[sr_addr];

  // Model: mq holds the push edge of every stored word. The head is visible
  // unless it was pushed at the most recent edge (one cycle to fall through).
  function automatic bit m_empty_n();
    return mq.size() > 0 && mq[0] != edge_no;
  endfunction
  function automatic bit m_full_n();
    return (mq.size() - int'(m_empty_n())) < DEPTH;
  endfunction

  task automatic chk(string n, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h at edge %0d", n, got, exp, edge_no);
    end
  endtask

  always @(posedge clk) begin
    m_po = if_read & if_read_ce & m_empty_n();
    m_pu = if_write & if_write_ce & m_full_n();
    edge_no++;
    started = 1;
    if (!reset_n || flush) begin
      mq.delete();
      exp_q.delete();
    end else begin
      if (m_po) void'(mq.pop_front());
      if (m_pu) begin
        mq.push_back(edge_no);
        exp_q.push_back(if_din);
      end
    end
  end

  always @(negedge clk) if (started) begin
    chk("empty_n", 32'(if_empty_n), 32'(m_empty_n()));
    chk("full_n", 32'(if_full_n), 32'(m_full_n()));
    chk("count", 32'(num_data_valid), 32'(mq.size()));
    chk("afull", 32'(if_almost_full), 32'(mq.size() >= AF));
    chk("cap", 32'(fifo_cap), 32'(DEPTH + 1));
    chk("sr_we", 32'(sr_we), 32'(reset_n & ~flush & if_write & if_write_ce & m_full_n()));
    if (reset_n && if_empty_n && if_read && if_read_ce) begin
      if (exp_q.size() == 0) chk("underrun", 32'(if_dout), 32'hDEAD_BEEF);
      else chk("dout", 32'(if_dout), 32'(exp_q.pop_front()));
    end
  end

  task automatic cyc(bit w, logic [DW-1:0] d, bit r, bit fl = 0, bit rn = 1, bit wce = 1, bit rce = 1);
    if_write = w; if_din = d; if_read = r; flush = fl; reset_n = rn;
    if_write_ce = wce; if_read_ce = rce;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (DEPTH + 3) cyc(0, '0, 1);
  endtask

  initial begin
    repeat (3) cyc(0, '0, 0, 0, 0);
    repeat (3) cyc(0, '0, 0);
    cyc(1, 8'hA, 0);
    repeat (2) cyc(0, '0, 0);
    cyc(0, '0, 1);
    repeat (2) cyc(0, '0, 0);
    for (int v = 1; v <= 6; v++) cyc(1, DW'(v), 0);
    cyc(0, '0, 0);
    drain();
    repeat (2) begin cyc(1, nv, 0); nv++; end
    repeat (100) begin cyc(1, nv, 1); nv++; end
    drain();
    for (int v = 1; v <= 3; v++) cyc(1, DW'(v), 0);
    cyc(1, 8'hF, 0, 1);
    cyc(1, 8'h7, 0);
    repeat (2) cyc(0, '0, 0);
    cyc(0, '0, 1);
    cyc(0, '0, 0);
    repeat (4) begin cyc(1, nv, 1); nv++; end
    cyc(1, 8'hEE, 1, 0, 0);
    repeat (3) begin cyc(1, nv, 0); nv++; end
    drain();
    repeat (1500) begin
      cyc(($urandom % 4) != 0, DW'($urandom), ($urandom % 3) != 0,
          ($urandom % 60) == 0, ($urandom % 90) != 0,
          ($urandom % 8) != 0, ($urandom % 8) != 0);
    end
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
